// File: rtl/chipper3d_pipe.sv
// Two-stage bufferless 3D deflection router node (CHIPPER style): stage A latches the six
// network inputs, stage B ejects, injects, and routes in priority order. Optional
// deflection counter is enabled with `define CHIPPER_DEFLECT_CNT_EN.
module chipper3d_pipe #(
  parameter int unsigned FLIT_W  = 32,
  parameter int unsigned COORD_W = 2,
  parameter int unsigned AGE_W   = 4,
  parameter int unsigned MY_X    = 1,
  parameter int unsigned MY_Y    = 1,
  parameter int unsigned MY_Z    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] north_in,
  input  logic [FLIT_W-1:0] south_in,
  input  logic [FLIT_W-1:0] east_in,
  input  logic [FLIT_W-1:0] west_in,
  input  logic [FLIT_W-1:0] up_in,
  input  logic [FLIT_W-1:0] down_in,
  output logic [FLIT_W-1:0] north_out,
  output logic [FLIT_W-1:0] south_out,
  output logic [FLIT_W-1:0] east_out,
  output logic [FLIT_W-1:0] west_out,
  output logic [FLIT_W-1:0] up_out,
  output logic [FLIT_W-1:0] down_out,
  input  logic [FLIT_W-1:0] pe_in,
  input  logic              inject_request,
  output logic              inject_grant,
  output logic [FLIT_W-1:0] pe_out
`ifdef CHIPPER_DEFLECT_CNT_EN
  ,
  output logic [15:0]       deflect_count
`endif
);

  localparam int NP = 6;
  localparam int NC = 7;
  localparam int unsigned VB = FLIT_W - 1;
  localparam int unsigned XH = FLIT_W - 2;
  localparam int unsigned YH = XH - COORD_W;
  localparam int unsigned ZH = YH - COORD_W;
  localparam int unsigned AH = ZH - COORD_W;
  localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MYC = COORD_W'(MY_Y);
  localparam logic [COORD_W-1:0] MZ = COORD_W'(MY_Z);

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic logic [AGE_W-1:0] age_of(input flit_t f);
    return f[AH -: AGE_W];
  endfunction

  // True when candidate j outranks candidate i; index NP is the injected flit.
  function automatic logic beats(input flit_t fj, input flit_t fi, input int j, input int i);
    if (!fj[VB]) return 1'b0;
    if (i == NP) return (j < NP);
    if (j == NP) return 1'b0;
    if (age_of(fj) != age_of(fi)) return (age_of(fj) > age_of(fi));
    return (j < i);
  endfunction

  function automatic logic is_local(input flit_t f);
    return f[VB] && (f[XH -: COORD_W] == MX) && (f[YH -: COORD_W] == MYC) &&
           (f[ZH -: COORD_W] == MZ);
  endfunction

  // Port index of the productive direction, 7 when already at destination.
  function automatic logic [2:0] prod_port(input flit_t f);
    if (f[XH -: COORD_W] > MX)  return 3'd2;
    if (f[XH -: COORD_W] < MX)  return 3'd3;
    if (f[YH -: COORD_W] > MYC) return 3'd0;
    if (f[YH -: COORD_W] < MYC) return 3'd1;
    if (f[ZH -: COORD_W] > MZ)  return 3'd4;
    if (f[ZH -: COORD_W] < MZ)  return 3'd5;
    return 3'd7;
  endfunction

  function automatic flit_t age_inc(input flit_t f);
    flit_t r;
    r = f;
    if (age_of(f) != '1) r[AH -: AGE_W] = age_of(f) + AGE_W'(1);
    return r;
  endfunction

  flit_t in_flit [NP];
  flit_t a_q     [NP];
  flit_t out_d   [NP];
  flit_t out_q   [NP];
  flit_t cand    [NC];
  flit_t ej_flit;
  flit_t pe_d, pe_q;
  logic  grant;
  logic  found;
  int    eidx;
  int    n_valid;
  int    rank    [NC];
  logic [NP-1:0] busy;
  logic [2:0]    prod;
  int            sel;
`ifdef CHIPPER_DEFLECT_CNT_EN
  logic [2:0]  n_defl;
  logic [15:0] dcnt_q;
  logic [16:0] dsum;
`endif

  assign in_flit[0] = north_in;
  assign in_flit[1] = south_in;
  assign in_flit[2] = east_in;
  assign in_flit[3] = west_in;
  assign in_flit[4] = up_in;
  assign in_flit[5] = down_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        a_q[i]   <= '0;
        out_q[i] <= '0;
      end
      pe_q <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        a_q[i]   <= in_flit[i][VB] ? in_flit[i] : '0;
        out_q[i] <= out_d[i];
      end
      pe_q <= pe_d;
    end
  end

  always_comb begin
    found   = 1'b0;
    eidx    = NP;
    ej_flit = '0;
    n_valid = 0;
    for (int i = 0; i < NP; i++) begin
      if (a_q[i][VB]) n_valid++;
      if (is_local(a_q[i]) && (!found || beats(a_q[i], ej_flit, i, eidx))) begin
        found   = 1'b1;
        eidx    = i;
        ej_flit = a_q[i];
      end
    end
    grant = inject_request && rst_n && ((n_valid - int'(found)) < NP);
    pe_d  = found ? ej_flit : '0;

    for (int i = 0; i < NP; i++) cand[i] = (found && i == eidx) ? '0 : a_q[i];
    cand[NP] = '0;
    if (grant) begin
      cand[NP]              = pe_in;
      cand[NP][VB]          = 1'b1;
      cand[NP][AH -: AGE_W] = '0;
    end

    for (int i = 0; i < NC; i++) begin
      rank[i] = 0;
      for (int j = 0; j < NC; j++)
        if (j != i && beats(cand[j], cand[i], j, i)) rank[i]++;
    end

    // Ranks of valid candidates are unique, so walking ranks visits flits in priority order.
    busy = '0;
    prod = 3'd7;
    sel  = NP;
    for (int i = 0; i < NP; i++) out_d[i] = '0;
`ifdef CHIPPER_DEFLECT_CNT_EN
    n_defl = '0;
`endif
    for (int r = 0; r < NC; r++) begin
      for (int i = 0; i < NC; i++) begin
        if (cand[i][VB] && rank[i] == r) begin
          prod = prod_port(cand[i]);
          sel  = NP;
          if (prod != 3'd7 && !busy[prod]) begin
            sel = int'(prod);
          end else begin
`ifdef CHIPPER_DEFLECT_CNT_EN
            n_defl = n_defl + 3'd1;
`endif
            for (int p = NP - 1; p >= 0; p--) if (!busy[p]) sel = p;
          end
          for (int p = 0; p < NP; p++) begin
            if (p == sel) begin
              out_d[p] = age_inc(cand[i]);
              busy[p]  = 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef CHIPPER_DEFLECT_CNT_EN
  assign dsum = {1'b0, dcnt_q} + 17'(n_defl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt_q <= '0;
    else        dcnt_q <= dsum[16] ? 16'hFFFF : dsum[15:0];
  end

  assign deflect_count = dcnt_q;
`endif

  assign inject_grant = grant;
  assign north_out    = out_q[0];
  assign south_out    = out_q[1];
  assign east_out     = out_q[2];
  assign west_out     = out_q[3];
  assign up_out       = out_q[4];
  assign down_out     = out_q[5];
  assign pe_out       = pe_q;

endmodule

// File: tb/tb_chipper3d_pipe.sv
// Scoreboard bench for chipper3d_pipe: directed flits with hand-computed routes, expected
// output snapshots queued per due cycle and compared by a negedge monitor.
module tb_chipper3d_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] north_in = '0, south_in = '0, east_in = '0, west_in = '0, up_in = '0;
  logic [31:0] down_in = '0, pe_in = '0;
  logic [31:0] north_out, south_out, east_out, west_out, up_out, down_out, pe_out;
  logic        inject_request = 1'b0;
  logic        inject_grant;
`ifdef CHIPPER_DEFLECT_CNT_EN
  logic [15:0] deflect_count;
`endif

  chipper3d_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .north_in       (north_in),
    .south_in       (south_in),
    .east_in        (east_in),
    .west_in        (west_in),
    .up_in          (up_in),
    .down_in        (down_in),
    .north_out      (north_out),
    .south_out      (south_out),
    .east_out       (east_out),
    .west_out       (west_out),
    .up_out         (up_out),
    .down_out       (down_out),
    .pe_in          (pe_in),
    .inject_request (inject_request),
    .inject_grant   (inject_grant),
    .pe_out         (pe_out)
`ifdef CHIPPER_DEFLECT_CNT_EN
    ,
    .deflect_count  (deflect_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [6:0][31:0] o;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  string pn[7] = '{"north", "south", "east", "west", "up", "down", "pe"};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flit with valid set: dest (x,y,z), age, 21-bit payload.
  function automatic logic [31:0] mk(input int x, input int y, input int z, input int age,
                                     input logic [20:0] pl);
    return {1'b1, 2'(x), 2'(y), 2'(z), 4'(age), pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive6(input logic [31:0] n, s, e, w, u, d);
    north_in = n; south_in = s; east_in = e; west_in = w; up_in = u; down_in = d;
  endtask

  task automatic push(input exp_t e);
    exp_t t;
    t     = e;
    t.due = cyc + 2;
    sb.push_back(t);
  endtask

  always @(negedge clk) begin
    logic [6:0][31:0] got;
    exp_t             e;
    got = {pe_out, down_out, up_out, west_out, east_out, south_out, north_out};
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check("missing_expected_output", 32'(cyc), 32'(e.due));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        for (int p = 0; p < 7; p++) check($sformatf("c%0d_%s", cyc, pn[p]), got[p], e.o[p]);
      end else begin
        for (int p = 0; p < 7; p++)
          if (got[p] != '0) check($sformatf("idle_c%0d_%s", cyc, pn[p]), got[p], 32'h0);
      end
    end
  end

  initial begin
    exp_t e;

    // Reset state with live-looking inputs
    north_in       = mk(2, 1, 1, 0, 21'h1);
    inject_request = 1'b1;
    pe_in          = mk(2, 1, 1, 0, 21'h2);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_north", north_out, 32'h0);
    check("rst_east", east_out, 32'h0);
    check("rst_pe", pe_out, 32'h0);
    check("rst_grant", 32'(inject_grant), 32'h0);
`ifdef CHIPPER_DEFLECT_CNT_EN
    check("rst_cnt", 32'(deflect_count), 32'h0);
`endif
    drive6('0, '0, '0, '0, '0, '0);
    inject_request = 1'b0;
    pe_in          = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single flit routed +X, age 0 -> 1
    e.o = '0; e.o[2] = mk(2, 1, 1, 1, 21'h123);
    drive6(mk(2, 1, 1, 0, 21'h123), '0, '0, '0, '0, '0); push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0); repeat (3) tick();

    // Contention for east: older south wins, north deflected to north_out
    e.o = '0; e.o[2] = mk(2, 1, 1, 6, 21'h22); e.o[0] = mk(2, 1, 1, 4, 21'h11);
    drive6(mk(2, 1, 1, 3, 21'h11), mk(2, 1, 1, 5, 21'h22), '0, '0, '0, '0); push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0); repeat (3) tick();

    // Two local flits of equal age: east ejected, west deflected
    e.o = '0; e.o[6] = mk(1, 1, 1, 2, 21'hA); e.o[0] = mk(1, 1, 1, 3, 21'hB);
    drive6('0, '0, mk(1, 1, 1, 2, 21'hA), mk(1, 1, 1, 2, 21'hB), '0, '0); push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0); repeat (3) tick();

    // Saturated age stays at 15
    e.o = '0; e.o[3] = mk(0, 1, 1, 15, 21'h5);
    drive6('0, '0, '0, mk(0, 1, 1, 15, 21'h5), '0, '0); push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0); repeat (3) tick();

    // Y and Z dimension routing
    e.o = '0;
    e.o[0] = mk(1, 2, 1, 1, 21'h1); e.o[5] = mk(1, 1, 0, 8, 21'h2); e.o[1] = mk(1, 0, 1, 2, 21'h3);
    drive6(mk(1, 2, 1, 0, 21'h1), '0, '0, '0, mk(1, 1, 0, 7, 21'h2), mk(1, 0, 1, 1, 21'h3));
    push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0); repeat (3) tick();

    // Full load: no injection possible
    e.o = '0;
    e.o[2] = mk(2, 1, 1, 7, 21'h5); e.o[0] = mk(2, 1, 1, 6, 21'h4);
    e.o[1] = mk(2, 1, 1, 5, 21'h3); e.o[3] = mk(2, 1, 1, 4, 21'h2);
    e.o[4] = mk(2, 1, 1, 3, 21'h1); e.o[5] = mk(2, 1, 1, 2, 21'h0);
    drive6(mk(2, 1, 1, 1, 21'h0), mk(2, 1, 1, 2, 21'h1), mk(2, 1, 1, 3, 21'h2),
           mk(2, 1, 1, 4, 21'h3), mk(2, 1, 1, 5, 21'h4), mk(2, 1, 1, 6, 21'h5));
    push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0);
    inject_request = 1'b1; pe_in = mk(0, 0, 0, 0, 21'h3F);
    #1 check("grant_full", 32'(inject_grant), 32'h0);
    tick(); inject_request = 1'b0; pe_in = '0; repeat (3) tick();

    // One local flit frees a slot: injection granted at age 0, leaves at age 1
    e.o = '0;
    e.o[2] = mk(2, 1, 1, 3, 21'h10); e.o[3] = mk(0, 1, 1, 3, 21'h11);
    e.o[6] = mk(1, 1, 1, 0, 21'h12); e.o[0] = mk(1, 2, 1, 3, 21'h13);
    e.o[4] = mk(1, 1, 2, 3, 21'h14); e.o[5] = mk(1, 1, 0, 3, 21'h15);
    e.o[1] = mk(1, 0, 1, 1, 21'h16);
    drive6(mk(2, 1, 1, 2, 21'h10), mk(0, 1, 1, 2, 21'h11), mk(1, 1, 1, 0, 21'h12),
           mk(1, 2, 1, 2, 21'h13), mk(1, 1, 2, 2, 21'h14), mk(1, 1, 0, 2, 21'h15));
    push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0);
    inject_request = 1'b1; pe_in = mk(1, 0, 1, 9, 21'h16);
    #1 check("grant_free", 32'(inject_grant), 32'h1);
    tick(); inject_request = 1'b0; pe_in = '0; repeat (3) tick();

    // Invalid inputs are ignored (monitor flags any leak)
    drive6(32'h7FFF_FFFF, '0, 32'h0123_4567, '0, '0, 32'h7000_0001);
    tick(); drive6('0, '0, '0, '0, '0, '0); repeat (3) tick();
`ifdef CHIPPER_DEFLECT_CNT_EN
    check("deflect_total", 32'(deflect_count), 32'd7);
`endif

    // Mid-stream reset discards the flit still in stage A
    e.o = '0; e.o[2] = mk(2, 1, 1, 1, 21'h77);
    drive6(mk(2, 1, 1, 0, 21'h77), '0, '0, '0, '0, '0); push(e);
    tick(); drive6(mk(0, 1, 1, 0, 21'h88), '0, '0, '0, '0, '0);
    tick(); drive6('0, '0, '0, '0, '0, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b0; inject_request = 1'b1; pe_in = mk(2, 1, 1, 0, 21'h99);
    sb.delete();
    #1;
    check("midrst_east", east_out, 32'h0);
    check("midrst_west", west_out, 32'h0);
    check("midrst_pe", pe_out, 32'h0);
    check("midrst_grant", 32'(inject_grant), 32'h0);
`ifdef CHIPPER_DEFLECT_CNT_EN
    check("midrst_cnt", 32'(deflect_count), 32'h0);
`endif
    tick();
    @(negedge clk);
    rst_n = 1'b1; inject_request = 1'b0; pe_in = '0;
    tick();
    e.o = '0; e.o[5] = mk(1, 1, 0, 1, 21'h99);
    drive6(mk(1, 1, 0, 0, 21'h99), '0, '0, '0, '0, '0); push(e);
    tick(); drive6('0, '0, '0, '0, '0, '0); repeat (4) tick();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chipper3d_pipe.md
CHIPPER3D_PIPE -- requirements
Module: chipper3d_pipe

Interface
REQ-001 The block SHALL have parameter FLIT_W, default 32, flit width in bits.
REQ-002 The block SHALL have parameter COORD_W, default 2, width of each destination coordinate.
REQ-003 The block SHALL have parameter AGE_W, default 4, width of the flit age field.
REQ-004 The block SHALL have parameters MY_X, MY_Y, MY_Z, default 1 each, giving the local node coordinates.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have ports north_in, south_in, east_in, west_in, up_in, down_in, each input, FLIT_W bits, network input flits (port index 0..5 in that order).
REQ-008 The block SHALL have ports north_out, south_out, east_out, west_out, up_out, down_out, each output, FLIT_W bits, network output flits.
REQ-009 The block SHALL have port pe_in, input, FLIT_W bits, the local injection flit.
REQ-010 The block SHALL have port inject_request, input, 1 bit, meaning pe_in is valid.
REQ-011 The block SHALL have port inject_grant, output, 1 bit, meaning pe_in is consumed at the next clk edge.
REQ-012 The block SHALL have port pe_out, output, FLIT_W bits, the ejected flit.

Function
REQ-013 The flit layout SHALL be: bit FLIT_W-1 valid; then dest X, dest Y, dest Z (COORD_W bits each, MSB-first); then age (AGE_W bits); remaining LSBs payload.
REQ-014 Stage A SHALL register all six network inputs every cycle; stage B SHALL compute eject/inject/route from the stage-A registers and register all outputs, giving exactly 2 cycles of input-to-output latency.
REQ-015 Priority SHALL be higher age first; ties go to the lower port index; the injected flit ranks last.
REQ-016 Among stage-A flits whose destination equals (MY_X,MY_Y,MY_Z), exactly the highest-priority flit SHALL be ejected to pe_out; the other local flits SHALL be deflected.
REQ-017 inject_grant SHALL be combinational, equal to inject_request AND (count of non-ejected valid stage-A flits < 6).
REQ-018 On a granted cycle, pe_in SHALL be injected with its age field forced to 0.
REQ-019 The productive port SHALL be the first differing dimension in X, Y, Z order: +X east, -X west, +Y north, -Y south, +Z up, -Z down.
REQ-020 Flits SHALL be assigned in priority order: the productive port if still free, otherwise the lowest-index free port (deflection).
REQ-021 Every valid flit leaving on a network port SHALL have its age incremented by 1, saturating at 2^AGE_W-1.
REQ-022 Outputs carrying no flit SHALL be all-zero.
REQ-023 Valid flits in (stage A + injected − ejected) SHALL equal valid flits out; no flit is dropped or duplicated.
REQ-024 Invalid inputs SHALL be ignored regardless of their other bits.

Reset
REQ-025 While rst_n is low, all stage registers, all *_out ports and the deflection counter SHALL be zero, and inject_grant SHALL be 0.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight flits; the first outputs after release SHALL reflect inputs sampled after release.

Configuration
REQ-027 With macro CHIPPER_DEFLECT_CNT_EN defined, the block SHALL add output deflect_count, 16 bits, incremented by the number of flits deflected each cycle, saturating at 0xFFFF.
REQ-028 Without CHIPPER_DEFLECT_CNT_EN, the block SHALL have no deflect_count port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-029 A bench SHALL drive north_in with a valid flit, dest (2,1,1), age 0 -> east_out carries it with age 1 exactly 2 cycles later; all other outputs are 0.
REQ-030 A bench SHALL drive north_in at age 3 and south_in at age 5, both dest (2,1,1) -> south flit exits east_out; north flit exits north_out (lowest free port); deflect_count +1 when enabled.
REQ-031 A bench SHALL drive east_in at age 2 and west_in at age 2, both dest (1,1,1) -> east flit is ejected on pe_out; west flit is deflected to north_out with age 3.
REQ-032 A bench SHALL drive all six inputs valid and non-local, with inject_request=1 -> inject_grant=0 in the route cycle and pe_in is not consumed; with one input local instead -> inject_grant=1, the injected flit appears at age 1.
REQ-033 A bench SHALL feed a flit at age 2^AGE_W-1 -> it exits with age unchanged (saturated).
REQ-034 A bench SHALL pulse rst_n low for 1 cycle mid-stream -> all outputs and the counter read 0 immediately; previously captured flits never appear.
